// File: rtl/enc_pkg.sv
// Shared types and helpers for the registered 8-to-3 priority encoder.
package enc_pkg;

  localparam int unsigned ENC_IN_W  = 8;
  localparam int unsigned ENC_OUT_W = 3;

  typedef logic [ENC_IN_W-1:0]  enc_vec_t;
  typedef logic [ENC_OUT_W-1:0] enc_idx_t;

  // Index of the most significant set bit; returns 0 for an all-zero vector.
  function automatic enc_idx_t f_prio_idx(input enc_vec_t vec);
    enc_idx_t idx;
    idx = '0;
    for (int unsigned k = 0; k < ENC_IN_W; k++) begin
      if (vec[k]) idx = k[ENC_OUT_W-1:0];
    end
    return idx;
  endfunction

endpackage

// File: rtl/enc8to3_reg_prio_enc_comb.sv
// Combinational MSB-priority encoder with an any-bit flag.
// With ONEHOT_CHECK_EN defined, also flags inputs with two or more bits set.
module prio_enc_comb
  import enc_pkg::*;
#(
  parameter int unsigned IN_W = ENC_IN_W
) (
  input  logic [IN_W-1:0]         vec,
  output logic [$clog2(IN_W)-1:0] idx,
  output logic                    any
`ifdef ONEHOT_CHECK_EN
  ,
  output logic                    multi
`endif
);

  localparam int unsigned OUT_W = $clog2(IN_W);

  // Scan upward so the highest set bit is the last one to write idx.
  always_comb begin
    idx = '0;
    for (int unsigned k = 0; k < IN_W; k++) begin
      if (vec[k]) idx = k[OUT_W-1:0];
    end
  end

  assign any = |vec;

`ifdef ONEHOT_CHECK_EN
  // Clearing the lowest set bit leaves something only if two or more were set.
  assign multi = |(vec & (vec - IN_W'(1)));
`endif

endmodule

// File: rtl/enc8to3_reg.sv
// Registered 8-to-3 priority encoder: y is the index of the highest set bit of i,
// valid marks a non-zero input, both one cycle after sampling.
// Optional macro ONEHOT_CHECK_EN adds the registered multi output (popcount >= 2).
module enc8to3_reg
  import enc_pkg::*;
#(
  parameter int unsigned IN_W = ENC_IN_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [IN_W-1:0]         i,
  output logic [$clog2(IN_W)-1:0] y,
  output logic                    valid
`ifdef ONEHOT_CHECK_EN
  ,
  output logic                    multi
`endif
);

  localparam int unsigned OUT_W = $clog2(IN_W);

  logic [OUT_W-1:0] idx_d;
  logic             any_d;
`ifdef ONEHOT_CHECK_EN
  logic             multi_d;
`endif

  prio_enc_comb #(
    .IN_W (IN_W)
  ) u_prio_enc (
    .vec   (i),
    .idx   (idx_d),
    .any   (any_d)
`ifdef ONEHOT_CHECK_EN
    ,
    .multi (multi_d)
`endif
  );

  // Output registers with synchronous active-low clear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      y     <= '0;
      valid <= 1'b0;
`ifdef ONEHOT_CHECK_EN
      multi <= 1'b0;
`endif
    end else begin
      y     <= idx_d;
      valid <= any_d;
`ifdef ONEHOT_CHECK_EN
      multi <= multi_d;
`endif
    end
  end

endmodule

// File: tb/tb_enc8to3_reg.sv
// Self-checking bench for enc8to3_reg: directed scenarios with literal
// expectations plus randomized traffic compared each cycle against a model.
// Build with or without ONEHOT_CHECK_EN.
module tb_enc8to3_reg;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] i;
  logic [2:0] y;
  logic       valid;
`ifdef ONEHOT_CHECK_EN
  logic       multi;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  enc8to3_reg #(
    .IN_W (8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .i     (i),
    .y     (y),
    .valid (valid)
`ifdef ONEHOT_CHECK_EN
    ,
    .multi (multi)
`endif
  );

  // Reference model: highest set bit from log2 arithmetic, popcount via $countones.
  logic [2:0] exp_y;
  logic       exp_valid;
  logic       exp_multi;
  logic       model_known = 1'b0;

  function automatic int msb_index(input logic [7:0] v);
    int n;
    n = int'(v);
    return (n == 0) ? 0 : ($clog2(n + 1) - 1);
  endfunction

  always @(posedge clk) begin
    if (rst_n === 1'b0) begin
      exp_y       <= 3'd0;
      exp_valid   <= 1'b0;
      exp_multi   <= 1'b0;
      model_known <= 1'b1;
    end else begin
      exp_y     <= 3'(msb_index(i));
      exp_valid <= (i != 8'h00);
      exp_multi <= ($countones(i) >= 2);
    end
  end

  // Per-cycle comparison against the model, sampled mid-cycle.
  always @(negedge clk) begin
    if (model_known) begin
      n_cmp++;
      if (y !== exp_y || valid !== exp_valid) begin
        n_err++;
        $display("FAIL model_yv t=%0t: got y=%0d valid=%b, required y=%0d valid=%b",
                 $time, y, valid, exp_y, exp_valid);
      end
`ifdef ONEHOT_CHECK_EN
      n_cmp++;
      if (multi !== exp_multi) begin
        n_err++;
        $display("FAIL model_multi t=%0t: got %b, required %b", $time, multi, exp_multi);
      end
`endif
    end
  end

  task automatic lit(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0d, required %0d", nm, act, req);
    end
  endtask

  // Apply one input set, clock it in, then settle just after the edge.
  task automatic step(input logic r, input logic [7:0] v);
    rst_n = r;
    i     = v;
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string nm, input int ey, input logic ev, input logic em);
    lit({nm, "_y"}, 32'(y), 32'(ey));
    lit({nm, "_valid"}, 32'(valid), 32'(ev));
`ifdef ONEHOT_CHECK_EN
    lit({nm, "_multi"}, 32'(multi), 32'(em));
`else
    if (em === 1'bx) $display("unexpected x flag in %s", nm);
`endif
  endtask

  typedef struct {
    logic       r;
    logic [7:0] v;
    int         ey;
    logic       ev;
  } vec_t;

  vec_t sweep[$];
  logic [7:0] tv;

  initial begin
    rst_n = 1'b0;
    i     = 8'hFF;
    @(negedge clk);

    // Reset held for two edges with all requests asserted.
    step(1'b0, 8'hFF); check_out("rst_edge1", 0, 1'b0, 1'b0);
    step(1'b0, 8'hFF); check_out("rst_edge2", 0, 1'b0, 1'b0);
    step(1'b1, 8'h00); check_out("rst_release_zero", 0, 1'b0, 1'b0);

    // Model sanity pins.
    lit("model_msb_24", 32'(msb_index(8'b0010_0100)), 32'd5);
    lit("model_msb_ff", 32'(msb_index(8'hFF)), 32'd7);
    lit("model_msb_01", 32'(msb_index(8'h01)), 32'd0);

    // One-hot sweep with a one-edge reset at 8'h10.
    sweep.push_back('{1'b1, 8'h01, 0, 1'b1});
    sweep.push_back('{1'b1, 8'h02, 1, 1'b1});
    sweep.push_back('{1'b1, 8'h04, 2, 1'b1});
    sweep.push_back('{1'b1, 8'h08, 3, 1'b1});
    sweep.push_back('{1'b0, 8'h10, 0, 1'b0});
    sweep.push_back('{1'b1, 8'h20, 5, 1'b1});
    sweep.push_back('{1'b1, 8'h40, 6, 1'b1});
    sweep.push_back('{1'b1, 8'h80, 7, 1'b1});
    foreach (sweep[k]) begin
      step(sweep[k].r, sweep[k].v);
      check_out($sformatf("sweep_%0d", k), sweep[k].ey, sweep[k].ev, 1'b0);
    end

    // Unreset one-hot pass for index 4.
    step(1'b1, 8'h10); check_out("onehot_10", 4, 1'b1, 1'b0);

    // Priority and zero input.
    step(1'b1, 8'b0010_0100); check_out("prio_24", 5, 1'b1, 1'b1);
    step(1'b1, 8'hFF);        check_out("prio_ff", 7, 1'b1, 1'b1);
    step(1'b1, 8'h80);        check_out("pre_zero_80", 7, 1'b1, 1'b0);
    step(1'b1, 8'h00);        check_out("zero", 0, 1'b0, 1'b0);

    // Back-to-back alternation, no bubbles.
    for (int k = 0; k < 16; k++) begin
      tv = (k % 2 == 0) ? 8'h01 : 8'h80;
      step(1'b1, tv);
      lit($sformatf("toggle_%0d", k), 32'(y), (k % 2 == 0) ? 32'd0 : 32'd7);
    end

    // Randomized traffic, biased toward sparse vectors, with occasional resets.
    for (int k = 0; k < 300; k++) begin
      case ($urandom_range(0, 3))
        0:       tv = 8'h00;
        1:       tv = 8'(1 << $urandom_range(0, 7));
        default: tv = 8'($urandom);
      endcase
      step(($urandom_range(0, 19) != 0), tv);
    end

    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/enc8to3_reg.md
Name: enc8to3_reg

Overview:
- Registered 8-to-3 binary encoder with priority resolution and a valid flag.
- Converts an 8-bit request/one-hot vector into the 3-bit index of the highest set bit.
- Sits between a one-hot select source (arbiter grants, interrupt lines) and index-consuming logic.
- One-cycle registered latency.

Parameters:
- IN_W, 8, input vector width; must be a power of two ≥ 2.
- OUT_W, $clog2(IN_W) = 3, encoded index width; derived, not overridable.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset; sampled on the rising edge of clk.
- i  input  IN_W  request vector; bit k set means index k is requested.
- y  output  OUT_W  encoded index of the highest set bit of i, registered.
- valid  output  1  high when the i sampled on the previous edge had at least one bit set.
- multi  output  1  high when the sampled i had more than one bit set. Present only with ONEHOT_CHECK_EN.

Behaviour:
- Reset: on a rising edge with rst_n=0, force y=0, valid=0 and multi=0; i is ignored on that edge.
- Normal edge (rst_n=1):
  - y <= index of the most significant set bit of i.
  - valid <= |i.
- Latency: exactly 1 cycle. The value of i at edge N appears on y/valid after edge N.
- No handshake. A new input is accepted every cycle, so throughput is 1 per cycle.
- Pure one-hot input 2^k: y = k, for k = 0..7.
  - 8'b00000001 → 0
  - 8'b00000010 → 1
  - …
  - 8'b10000000 → 7
- Multiple bits set: highest index wins (MSB priority), e.g. 8'b00100100 → 5.
- All-zero input: y <= 0 and valid <= 0. Consumers must qualify y with valid, because y=0 is ambiguous without it.
- Reset asserted mid-stream: outputs clear on that edge. The first post-reset result is available one edge after rst_n returns high.
- No X propagation from reset: all outputs are defined from the first reset edge onward.
- Combinational path: the priority encode is combinational from i to the register D-inputs. No combinational path from i to any output.

Optional Feature:
- Macro ONEHOT_CHECK_EN.
- Defined:
  - Adds output port multi.
  - multi <= 1 when popcount(i) ≥ 2, registered with the same 1-cycle latency as y.
  - multi resets to 0 synchronously.
  - y still reports the MSB-priority index.
- Not defined:
  - The multi port does not exist.
  - No population-count logic is synthesized.
  - y and valid behaviour are identical to the defined case.

Decomposition:
- Package enc_pkg:
  - localparams ENC_IN_W=8 and ENC_OUT_W=3.
  - typedefs enc_vec_t (logic [ENC_IN_W-1:0]) and enc_idx_t (logic [ENC_OUT_W-1:0]).
  - pure function f_prio_idx(enc_vec_t) returning the MSB-priority index, reusable elsewhere.
- One natural sub-module: prio_enc_comb.
  - Combinational IN_W→OUT_W priority encoder plus any-bit flag.
  - Instantiated once inside enc8to3_reg, which owns only the output registers and reset.

Test Plan:
- Reset:
  - Drive i=8'hFF and hold rst_n=0 for 2 edges → y=0, valid=0, multi=0 after each edge.
  - Release rst_n with i=8'h00 → outputs remain 0.
- One-hot sweep: apply i = 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80 on consecutive edges → one cycle later y = 0,1,2,3,4,5,6,7 respectively, valid=1, multi=0.
- Priority: i=8'b00100100 → y=5, valid=1, multi=1 (with ONEHOT_CHECK_EN). i=8'hFF → y=7, multi=1.
- Zero input: i=8'h00 following i=8'h80 → after the next edge y=0, valid=0.
- Mid-stream reset:
  - During the one-hot sweep, assert rst_n=0 for one edge at i=8'h10 → outputs 0 after that edge.
  - Deassert with i=8'h20 → y=5, valid=1 one edge later.
- Back-to-back toggling: alternate i=8'h01 and i=8'h80 every cycle for 16 cycles → y alternates 0/7 with exactly one-cycle lag and no bubbles.
